// File: rtl/plic_pkg.sv
// Shared types and defaults for the per-hart PLIC claim stage.
// The arbitration FSM only needs two states: settling and result valid.
package plic_pkg;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_VALID = 1'b1
    } plic_state_e;

    localparam int unsigned PLIC_ID_NUM   = 10;
    localparam int unsigned PLIC_PRIO_BIT = 5;
    localparam int unsigned PLIC_ARB_LAT  = 2;
    localparam int unsigned PLIC_CNT_W    = 4;

    localparam logic [PLIC_ID_NUM-1:0] ID_NONE = '0;

    // A winner interrupts only if it exists, is not the reserved id and beats the threshold.
    function automatic logic winner_qualifies(
        input logic req,
        input logic id_is_none,
        input logic prio_above_th
    );
        return req && !id_is_none && prio_above_th;
    endfunction

endpackage

// File: rtl/plic_settle_cnt.sv
// Loadable down-counter that times the arbiter tree settling window.
// done_o flags the last settle cycle; the owner reloads it on every restart.
module plic_settle_cnt
    import plic_pkg::*;
#(
    parameter int unsigned          CNT_W    = PLIC_CNT_W,
    parameter logic [CNT_W-1:0]     LOAD_VAL = CNT_W'(PLIC_ARB_LAT)
) (
    input  logic clk_i,
    input  logic rst_b_i,
    input  logic load_i,
    output logic done_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_b_i || load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/plic_hart_claim_ctrl.sv
// Per-hart stage after the PLIC arbiter tree: waits for the tree to settle, latches
// the winner, raises the hart interrupt, serves claim reads and forwards completions.
module plic_hart_claim_ctrl
    import plic_pkg::*;
#(
    parameter int unsigned ID_NUM   = PLIC_ID_NUM,
    parameter int unsigned PRIO_BIT = PLIC_PRIO_BIT,
    parameter int unsigned ARB_LAT  = PLIC_ARB_LAT
) (
    input  logic                plic_clk,
    input  logic                plicrst_b,
    input  logic                arb_upd,
    input  logic                arb_out_req,
    input  logic [ID_NUM-1:0]   arb_out_id,
    input  logic [PRIO_BIT-1:0] arb_out_prio,
    input  logic [PRIO_BIT-1:0] hart_th,
    input  logic                claim_req,
    output logic                claim_ack,
    output logic [ID_NUM-1:0]   claim_id,
    output logic                pend_clr_vld,
    output logic [ID_NUM-1:0]   pend_clr_id,
    input  logic                cmplt_vld,
    input  logic [ID_NUM-1:0]   cmplt_id,
    output logic                cmplt_clr_vld,
    output logic [ID_NUM-1:0]   cmplt_clr_id,
    output logic                hart_int_req
);

    localparam logic [ID_NUM-1:0]     ID0 = ID_NUM'(ID_NONE);
    localparam logic [PLIC_CNT_W-1:0] LAT = PLIC_CNT_W'(ARB_LAT);

    plic_state_e       state_q, state_d;
    logic              res_vld_q, res_vld_d;
    logic [ID_NUM-1:0] res_id_q, res_id_d;
    logic              hart_int_q, hart_int_d;
    logic              claim_ack_q;
    logic [ID_NUM-1:0] claim_id_q;
    logic              pend_clr_vld_q;
    logic [ID_NUM-1:0] pend_clr_id_q;
    logic              cmplt_clr_vld_q;
    logic [ID_NUM-1:0] cmplt_clr_id_q;

    logic settle_done;
    logic cnt_load;
    logic capture;
    logic claim_accept;

    // The counter stays parked at ARB_LAT outside the settle window so every
    // entry into ARB starts a full window.
    assign cnt_load     = arb_upd || (state_q != ST_ARB) || settle_done;
    assign capture      = (state_q == ST_ARB) && settle_done && !arb_upd;
    assign claim_accept = (state_q == ST_VALID) && claim_req;

    plic_settle_cnt #(
        .CNT_W    (PLIC_CNT_W),
        .LOAD_VAL (LAT)
    ) u_settle_cnt (
        .clk_i   (plic_clk),
        .rst_b_i (plicrst_b),
        .load_i  (cnt_load),
        .done_o  (settle_done)
    );

    always_comb begin
        state_d   = state_q;
        res_vld_d = res_vld_q;
        res_id_d  = res_id_q;
        unique case (state_q)
            ST_ARB: begin
                if (capture) begin
                    state_d   = ST_VALID;
                    res_vld_d = winner_qualifies(arb_out_req,
                                                 arb_out_id == ID0,
                                                 arb_out_prio > hart_th);
                    res_id_d  = arb_out_id;
                end
            end
            ST_VALID: begin
                // A claim consumes the held result even when arb_upd arrives with it.
                if (claim_req || arb_upd) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
        hart_int_d = (state_d == ST_VALID) && res_vld_d;
    end

    always_ff @(posedge plic_clk) begin
        if (!plicrst_b) begin
            state_q        <= ST_ARB;
            res_vld_q      <= 1'b0;
            res_id_q       <= ID0;
            hart_int_q     <= 1'b0;
            claim_ack_q    <= 1'b0;
            claim_id_q     <= ID0;
            pend_clr_vld_q <= 1'b0;
            pend_clr_id_q  <= ID0;
        end else begin
            state_q        <= state_d;
            res_vld_q      <= res_vld_d;
            res_id_q       <= res_id_d;
            hart_int_q     <= hart_int_d;
            claim_ack_q    <= claim_accept;
            claim_id_q     <= (claim_accept && res_vld_q) ? res_id_q : ID0;
            pend_clr_vld_q <= claim_accept && res_vld_q;
            pend_clr_id_q  <= (claim_accept && res_vld_q) ? res_id_q : ID0;
        end
    end

    always_ff @(posedge plic_clk) begin
        if (!plicrst_b) begin
            cmplt_clr_vld_q <= 1'b0;
            cmplt_clr_id_q  <= ID0;
        end else begin
            cmplt_clr_vld_q <= cmplt_vld && (cmplt_id != ID0);
            cmplt_clr_id_q  <= (cmplt_vld && (cmplt_id != ID0)) ? cmplt_id : ID0;
        end
    end

    assign claim_ack     = claim_ack_q;
    assign claim_id      = claim_id_q;
    assign pend_clr_vld  = pend_clr_vld_q;
    assign pend_clr_id   = pend_clr_id_q;
    assign cmplt_clr_vld = cmplt_clr_vld_q;
    assign cmplt_clr_id  = cmplt_clr_id_q;
    assign hart_int_req  = hart_int_q;

endmodule

// File: tb/tb_plic_hart_claim_ctrl.sv
// Directed bench for plic_hart_claim_ctrl: claim and completion results are queued
// when driven and popped when the DUT acknowledges them.
module tb_plic_hart_claim_ctrl;

    typedef struct packed {
        logic [9:0] id;
        logic       pclr;
    } claim_exp_t;

    logic       clk;
    logic       plicrst_b;
    logic       arb_upd;
    logic       arb_out_req;
    logic [9:0] arb_out_id;
    logic [4:0] arb_out_prio;
    logic [4:0] hart_th;
    logic       claim_req;
    logic       claim_ack;
    logic [9:0] claim_id;
    logic       pend_clr_vld;
    logic [9:0] pend_clr_id;
    logic       cmplt_vld;
    logic [9:0] cmplt_id;
    logic       cmplt_clr_vld;
    logic [9:0] cmplt_clr_id;
    logic       hart_int_req;

    logic [33:0] outs;
    assign outs = {claim_ack, claim_id, pend_clr_vld, pend_clr_id,
                   cmplt_clr_vld, cmplt_clr_id, hart_int_req};

    int n_assert = 0;
    int n_fail   = 0;

    claim_exp_t claim_q[$];
    logic [9:0] cmplt_q[$];

    plic_hart_claim_ctrl #(
        .ID_NUM   (10),
        .PRIO_BIT (5),
        .ARB_LAT  (2)
    ) dut (
        .plic_clk      (clk),
        .plicrst_b     (plicrst_b),
        .arb_upd       (arb_upd),
        .arb_out_req   (arb_out_req),
        .arb_out_id    (arb_out_id),
        .arb_out_prio  (arb_out_prio),
        .hart_th       (hart_th),
        .claim_req     (claim_req),
        .claim_ack     (claim_ack),
        .claim_id      (claim_id),
        .pend_clr_vld  (pend_clr_vld),
        .pend_clr_id   (pend_clr_id),
        .cmplt_vld     (cmplt_vld),
        .cmplt_id      (cmplt_id),
        .cmplt_clr_vld (cmplt_clr_vld),
        .cmplt_clr_id  (cmplt_clr_id),
        .hart_int_req  (hart_int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_claim(input logic [9:0] id, input logic pclr);
        claim_exp_t e;
        e.id   = id;
        e.pclr = pclr;
        claim_q.push_back(e);
    endtask

    // Restart arbitration; returns in the cycle the new result becomes visible.
    task automatic rearb();
        arb_upd = 1'b1;
        cyc();
        arb_upd = 1'b0;
        cyc();
        cyc();
    endtask

    // Scoreboard side: compare every DUT output event against the queued expectation.
    always @(negedge clk) begin
        if (claim_ack === 1'b1) begin
            if (claim_q.size() == 0) begin
                check("claim_unexpected", claim_ack, 0);
            end else begin
                claim_exp_t e;
                e = claim_q.pop_front();
                check("claim_id", claim_id, e.id);
                check("pend_clr_vld", pend_clr_vld, e.pclr);
                if (e.pclr) check("pend_clr_id", pend_clr_id, e.id);
                $display("claim ack: id=%0d pend_clr=%0b", claim_id, pend_clr_vld);
            end
        end else if (pend_clr_vld === 1'b1) begin
            check("pend_stray", pend_clr_vld, 0);
        end
        if (cmplt_clr_vld === 1'b1) begin
            if (cmplt_q.size() == 0) begin
                check("cmplt_unexpected", cmplt_clr_vld, 0);
            end else begin
                logic [9:0] eid;
                eid = cmplt_q.pop_front();
                check("cmplt_clr_id", cmplt_clr_id, eid);
                $display("completion fwd: id=%0d", cmplt_clr_id);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        plicrst_b    = 1'b0;
        arb_upd      = 1'b0;
        arb_out_req  = 1'b1;
        arb_out_id   = 10'd5;
        arb_out_prio = 5'd4;
        hart_th      = 5'd0;
        claim_req    = 1'b0;
        cmplt_vld    = 1'b0;
        cmplt_id     = 10'd0;

        // Reset with a request present at the tree root.
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_outs", outs, 0);
        end
        plicrst_b = 1'b1;
        check("rst_first_cycle", outs, 0);
        cyc();
        check("rst_hint_c2", hart_int_req, 0);
        cyc();
        check("rst_hint_c3", hart_int_req, 1);

        // Threshold is strict.
        arb_out_prio = 5'd3;
        hart_th      = 5'd3;
        rearb();
        check("th_equal_hint", hart_int_req, 0);
        cyc();
        check("th_equal_hint_hold", hart_int_req, 0);
        hart_th = 5'd2;
        arb_upd = 1'b1;
        cyc();
        arb_upd = 1'b0;
        check("th_lower_c1", hart_int_req, 0);
        cyc();
        check("th_lower_c2", hart_int_req, 0);
        cyc();
        check("th_lower_c3", hart_int_req, 1);

        arb_out_prio = 5'd0;
        hart_th      = 5'd0;
        rearb();
        check("prio0_hint", hart_int_req, 0);
        arb_out_id   = 10'd0;
        arb_out_prio = 5'd7;
        rearb();
        check("id0_hint", hart_int_req, 0);

        // Claim from VALID.
        arb_out_id   = 10'd5;
        arb_out_prio = 5'd4;
        hart_th      = 5'd2;
        rearb();
        check("claim_pre_hint", hart_int_req, 1);
        claim_req = 1'b1;
        exp_claim(10'd5, 1'b1);
        cyc();
        claim_req = 1'b0;
        check("claim_ack", claim_ack, 1);
        check("claim_hint_drop", hart_int_req, 0);
        cyc();
        check("claim_ack_pulse", claim_ack, 0);
        cyc();

        // Claim raised while the tree is settling after a change.
        arb_out_id   = 10'd7;
        arb_out_prio = 5'd6;
        arb_upd      = 1'b1;
        cyc();
        arb_upd   = 1'b0;
        claim_req = 1'b1;
        exp_claim(10'd7, 1'b1);
        cyc();
        check("stall_ack_c2", claim_ack, 0);
        cyc();
        check("stall_ack_c3", claim_ack, 0);
        check("stall_hint_c3", hart_int_req, 1);
        cyc();
        claim_req = 1'b0;
        check("stall_ack_c4", claim_ack, 1);

        // Claim with nothing pending.
        arb_out_req = 1'b0;
        rearb();
        check("empty_hint", hart_int_req, 0);
        claim_req = 1'b1;
        exp_claim(10'd0, 1'b0);
        cyc();
        claim_req = 1'b0;
        check("empty_ack", claim_ack, 1);

        // Completions: non-zero forwarded, id 0 dropped.
        cmplt_vld = 1'b1;
        cmplt_id  = 10'd5;
        cmplt_q.push_back(10'd5);
        cyc();
        check("cmplt_vld_5", cmplt_clr_vld, 1);
        cmplt_id = 10'd0;
        cyc();
        check("cmplt_vld_0", cmplt_clr_vld, 0);
        cmplt_vld = 1'b0;
        cyc();
        check("cmplt_idle", cmplt_clr_vld, 0);

        // Completion coinciding with a claim.
        arb_out_req  = 1'b1;
        arb_out_id   = 10'd5;
        arb_out_prio = 5'd4;
        rearb();
        claim_req = 1'b1;
        cmplt_vld = 1'b1;
        cmplt_id  = 10'd5;
        exp_claim(10'd5, 1'b1);
        cmplt_q.push_back(10'd5);
        cyc();
        claim_req = 1'b0;
        cmplt_vld = 1'b0;
        check("coinc_ack", claim_ack, 1);
        check("coinc_cmplt", cmplt_clr_vld, 1);
        cyc();

        // Reset while a claim is stalled: it must vanish without an ack.
        arb_upd = 1'b1;
        cyc();
        arb_upd   = 1'b0;
        claim_req = 1'b1;
        cyc();
        plicrst_b = 1'b0;
        cyc();
        claim_req = 1'b0;
        check("abort_rst_outs", outs, 0);
        plicrst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("abort_no_ack", claim_ack, 0);
        end
        check("abort_hint_back", hart_int_req, 1);

        cyc();
        check("claim_q_empty", claim_q.size(), 0);
        check("cmplt_q_empty", cmplt_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
